// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: default sizes,
// FSM state encoding and the width helpers used to size id and counter fields.
package fifo_arb_pkg;

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_MAX_BURST  = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Port ids need at least one bit even when clog2 would give zero.
  function automatic int id_width(input int num_ports);
    return (clog2(num_ports) < 1) ? 1 : clog2(num_ports);
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// Round-robin picker: first requester strictly after last_id_i in cyclic order,
// built as rotate -> lowest-index priority encode -> un-rotate.
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ID_WIDTH  = id_width(DEF_NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [ID_WIDTH-1:0]  last_id_i,
  output logic [ID_WIDTH-1:0]  pick_o,
  output logic                 any_req_o
);

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [2*NUM_PORTS-1:0] req_shift;
  logic [NUM_PORTS-1:0]   req_rot;
  int                     start;
  int                     offset;
  int                     sum;

  assign any_req_o = |req_i;
  assign req_dbl   = {req_i, req_i};

  always_comb begin
    start = int'(last_id_i) + 1;
    if (start >= NUM_PORTS) start = 0;
    req_shift = req_dbl >> start;
    req_rot   = req_shift[NUM_PORTS-1:0];
    // Scan downwards so the lowest rotated index (closest after last_id) wins.
    offset = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = k;
    end
    sum = start + offset;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    pick_o = ID_WIDTH'(sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port among
// NUM_PORTS writers; forwards source id and last flag with each word.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int ID_WIDTH   = id_width(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_din,
  input  logic [NUM_PORTS-1:0]            req_wr_en,
  input  logic [NUM_PORTS-1:0]            req_last,
  output logic [NUM_PORTS-1:0]            req_full,
  output logic [DATA_WIDTH-1:0]           dout,
  output logic                            wr_en,
  output logic [ID_WIDTH-1:0]             dout_id,
  output logic                            dout_last,
  input  logic                            full,
  output logic                            grant_valid,
  output logic [ID_WIDTH-1:0]             grant_id
);

  localparam int                   CNT_WIDTH = clog2(MAX_BURST + 1);
  localparam logic [ID_WIDTH-1:0]  PTR_RESET = ID_WIDTH'(NUM_PORTS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_BURST - 1);

  arb_state_e            state_q;
  logic [ID_WIDTH-1:0]   grant_id_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [ID_WIDTH-1:0]   pick;
  logic                  any_req;
  logic                  release_now;
  logic [DATA_WIDTH-1:0] din_arr [NUM_PORTS];

  fifo_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH)
  ) u_picker (
    .req_i     (req_wr_en),
    .last_id_i (ptr_q),
    .pick_o    (pick),
    .any_req_o (any_req)
  );

  assign grant_valid = (state_q == ST_GRANT);
  assign grant_id    = grant_id_q;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign din_arr[gi]  = req_din[DATA_WIDTH*gi +: DATA_WIDTH];
      assign req_full[gi] = rst | full | ~(grant_valid && (grant_id_q == ID_WIDTH'(gi)));
    end
  endgenerate

  assign wr_en     = grant_valid & req_wr_en[grant_id_q] & ~full & ~rst;
  assign dout      = din_arr[grant_id_q];
  assign dout_id   = grant_id_q;
  assign dout_last = req_last[grant_id_q];

  // Last flag and burst limit on the same word collapse into one release.
  assign release_now = req_last[grant_id_q] || (cnt_q == CNT_LAST);
  assign cnt_d       = cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_id_q <= '0;
      ptr_q      <= PTR_RESET;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q    <= ST_GRANT;
            grant_id_q <= pick;
            cnt_q      <= '0;
          end
        end
        ST_GRANT: begin
          // Stalls (full or granted port idle) simply hold; no timeout.
          if (wr_en) begin
            if (release_now) begin
              state_q <= ST_IDLE;
              ptr_q   <= grant_id_q;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
